// File: rtl/mmio_timer_pkg.sv
// Shared register map for the MMIO timer responder.
// Byte offsets within the 32-byte window and CTRL/STATUS bit positions.
package mmio_timer_pkg;

    localparam logic [4:0] OFS_CTRL    = 5'h00;
    localparam logic [4:0] OFS_COUNT   = 5'h04;
    localparam logic [4:0] OFS_COMPARE = 5'h08;
    localparam logic [4:0] OFS_STATUS  = 5'h0C;
    localparam logic [4:0] OFS_PRESC   = 5'h10;

    localparam int CTRL_W           = 3;
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: tick pulses when the running count equals presc.
// Ports: CLK, RST (async low), en, presc, clr -> tick.
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == presc);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt <= '0;
        end else if (!en || clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// MMIO timer on the data bus: decode, register file, counter, IRQ.
// Ports: CLK, RST, Addr, Data (inout), R_W, CS -> Hit, IRQ.
module mmio_timer_responder
    import mmio_timer_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'h800,
    parameter int          PRESC_W   = 16,
    parameter int          CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] Addr,
    inout  wire  [31:0] Data,
    input  logic        R_W,
    input  logic        CS,
    output logic        Hit,
    output logic        IRQ
);

    logic [CTRL_W-1:0]  ctrl, ctrl_nx;
    logic [CNT_W-1:0]   count, count_nx;
    logic [CNT_W-1:0]   compare;
    logic               match, match_nx;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [31:0]        rdata;
    logic [31:0]        wdata;

    logic sel_ctrl, sel_count, sel_compare, sel_status, sel_presc;
    logic wr_ctrl, wr_count, wr_compare, wr_status, wr_presc;
    logic rd_en, wr_en;

    // Byte lane bits are don't-care for word accesses.
    logic unused_addr;
    assign unused_addr = ^Addr[1:0];

    assign Hit   = CS && (Addr[11:5] == BASE_ADDR[11:5]);
    assign rd_en = Hit && !R_W;
    assign wr_en = Hit && R_W;
    assign wdata = Data;

    assign sel_ctrl    = Addr[4:2] == OFS_CTRL[4:2];
    assign sel_count   = Addr[4:2] == OFS_COUNT[4:2];
    assign sel_compare = Addr[4:2] == OFS_COMPARE[4:2];
    assign sel_status  = Addr[4:2] == OFS_STATUS[4:2];
    assign sel_presc   = Addr[4:2] == OFS_PRESC[4:2];

    assign wr_ctrl    = wr_en && sel_ctrl;
    assign wr_count   = wr_en && sel_count;
    assign wr_compare = wr_en && sel_compare;
    assign wr_status  = wr_en && sel_status;
    assign wr_presc   = wr_en && sel_presc;

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .CLK   (CLK),
        .RST   (RST),
        .en    (ctrl[CTRL_EN]),
        .presc (presc),
        .clr   (wr_presc),
        .tick  (tick)
    );

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ctrl:    rdata = 32'(ctrl);
            sel_count:   rdata = 32'(count);
            sel_compare: rdata = 32'(compare);
            sel_status:  rdata = 32'(match);
            sel_presc:   rdata = 32'(presc);
            default:     rdata = '0;
        endcase
    end

    assign Data = rd_en ? rdata : 'z;

    // Clear is applied before the tick so a same-cycle match wins;
    // the CPU COUNT write is applied last so it overrides the tick.
    always_comb begin
        ctrl_nx  = ctrl;
        count_nx = count;
        match_nx = match;
        if (wr_status && wdata[STATUS_MATCH]) begin
            match_nx = 1'b0;
        end
        if (tick) begin
            if (count == compare) begin
                match_nx = 1'b1;
                count_nx = ctrl[CTRL_AUTO_RELOAD] ? '0
                                                  : count + CNT_W'(1);
            end else begin
                count_nx = count + CNT_W'(1);
            end
        end
        if (wr_count) begin
            count_nx = wdata[CNT_W-1:0];
        end
        if (wr_ctrl) begin
            ctrl_nx = wdata[CTRL_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= '1;
            match   <= 1'b0;
            presc   <= '0;
            IRQ     <= 1'b0;
        end else begin
            ctrl  <= ctrl_nx;
            count <= count_nx;
            match <= match_nx;
            IRQ   <= match_nx && ctrl_nx[CTRL_IRQ_EN];
            if (wr_compare) begin
                compare <= wdata[CNT_W-1:0];
            end
            if (wr_presc) begin
                presc <= wdata[PRESC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder.
// Scenario tasks with inline comparisons and a summary count.
module tb_mmio_timer_responder;
    import mmio_timer_pkg::*;

    localparam logic [11:0] A_CTRL = 12'h800 + {7'd0, OFS_CTRL};
    localparam logic [11:0] A_CNT  = 12'h800 + {7'd0, OFS_COUNT};
    localparam logic [11:0] A_CMP  = 12'h800 + {7'd0, OFS_COMPARE};
    localparam logic [11:0] A_STAT = 12'h800 + {7'd0, OFS_STATUS};
    localparam logic [11:0] A_PRE  = 12'h800 + {7'd0, OFS_PRESC};

    logic        CLK, RST, R_W, CS;
    logic [11:0] Addr;
    wire  [31:0] Data;
    logic        Hit, IRQ;
    logic [31:0] drv_data;
    logic        drv_en;

    int n_cmp = 0;
    int n_bad = 0;

    assign Data = drv_en ? drv_data : 'z;

    mmio_timer_responder dut (
        .CLK  (CLK),
        .RST  (RST),
        .Addr (Addr),
        .Data (Data),
        .R_W  (R_W),
        .CS   (CS),
        .Hit  (Hit),
        .IRQ  (IRQ)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        Addr = a; drv_data = v; drv_en = 1; R_W = 1; CS = 1;
        @(posedge CLK);
        #1;
        CS = 0; R_W = 0; drv_en = 0;
    endtask

    task automatic rd(input logic [11:0] a,
                      output logic [31:0] d, output logic h);
        Addr = a; R_W = 0; CS = 1; drv_en = 0;
        #1;
        d = Data; h = Hit;
        CS = 0;
    endtask

    task automatic test_por();
        logic [31:0] d; logic h;
        rd(A_CTRL, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL por_ctrl got %h exp 0", d); end
        rd(A_CMP, d, h);
        n_cmp++; if (d !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL por_compare got %h exp ffffffff", d); end
        rd(A_STAT, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL por_status got %h exp 0", d); end
        n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL por_irq got %b exp 0", IRQ); end
    endtask

    task automatic test_decode();
        logic [31:0] d; logic h;
        wr(A_CNT, 32'h1234);
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'h1234 || h !== 1'b1) begin n_bad++; $display("FAIL dec_count got %h/%b exp 1234/1", d, h); end
        rd(12'h806, d, h);
        n_cmp++; if (d !== 32'h1234) begin n_bad++; $display("FAIL dec_bytelane got %h exp 1234", d); end
        rd(12'h7FC, d, h);
        n_cmp++; if (h !== 1'b0 || !(d === 'z || d === '0)) begin n_bad++; $display("FAIL dec_below got %h/%b exp z/0", d, h); end
        rd(12'h004, d, h);
        n_cmp++; if (h !== 1'b0 || !(d === 'z || d === '0)) begin n_bad++; $display("FAIL dec_alias got %h/%b exp z/0", d, h); end
        Addr = A_CNT; R_W = 0; CS = 0; #1;
        n_cmp++; if (Hit !== 1'b0 || !(Data === 'z || Data === '0)) begin n_bad++; $display("FAIL dec_nocs got %h/%b exp z/0", Data, Hit); end
        wr(12'h004, 32'h99);
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'h1234) begin n_bad++; $display("FAIL dec_miss_wr got %h exp 1234", d); end
        wr(12'h818, 32'hDEAD);
        rd(12'h818, d, h);
        n_cmp++; if (d !== 32'h0 || h !== 1'b1) begin n_bad++; $display("FAIL dec_resv got %h/%b exp 0/1", d, h); end
        wr(A_CTRL, 32'hFFFFFFF8);
        rd(A_CTRL, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL dec_ctrl_hi got %h exp 0", d); end
        wr(A_PRE, 32'h12345);
        rd(A_PRE, d, h);
        n_cmp++; if (d !== 32'h2345) begin n_bad++; $display("FAIL dec_presc got %h exp 2345", d); end
    endtask

    task automatic test_prescale();
        logic [31:0] d; logic h;
        wr(A_PRE, 32'd3);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'd1);
        step(4);
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL pre_4clk got %0d exp 1", d); end
        step(16);
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL pre_20clk got %0d exp 5", d); end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_match();
        logic [31:0] d, s; logic h;
        wr(A_PRE, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'd7);
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL mat_start got %0d exp 0", d); end
        for (int k = 1; k <= 5; k++) begin
            step(1);
            rd(A_CNT, d, h);
            rd(A_STAT, s, h);
            n_cmp++;
            if (d !== 32'(k) || s !== 32'd0 || IRQ !== 1'b0) begin
                n_bad++; $display("FAIL mat_seq%0d got %0d/%h/%b exp %0d/0/0", k, d, s, IRQ, k);
            end
        end
        step(1);
        rd(A_CNT, d, h);
        rd(A_STAT, s, h);
        n_cmp++; if (d !== 32'd0 || s !== 32'd1) begin n_bad++; $display("FAIL mat_reload got %0d/%h exp 0/1", d, s); end
        n_cmp++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL mat_irq got %b exp 1", IRQ); end
        wr(A_STAT, 32'd1);
        rd(A_STAT, s, h);
        n_cmp++; if (s !== 32'd0 || IRQ !== 1'b0) begin n_bad++; $display("FAIL mat_w1c got %h/%b exp 0/0", s, IRQ); end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_wrap();
        logic [31:0] d, s; logic h;
        wr(A_STAT, 32'd1);
        wr(A_CMP, 32'd3);
        wr(A_CNT, 32'hFFFFFFFF);
        wr(A_CTRL, 32'd1);
        step(1);
        rd(A_CNT, d, h);
        rd(A_STAT, s, h);
        n_cmp++; if (d !== 32'd0 || s !== 32'd0) begin n_bad++; $display("FAIL wrap got %h/%h exp 0/0", d, s); end
        step(4);
        rd(A_CNT, d, h);
        rd(A_STAT, s, h);
        n_cmp++; if (d !== 32'd4 || s !== 32'd1) begin n_bad++; $display("FAIL wrap_noreload got %0d/%h exp 4/1", d, s); end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_collision();
        logic [31:0] d, s; logic h;
        wr(A_STAT, 32'd1);
        wr(A_CMP, 32'd50);
        wr(A_CNT, 32'd40);
        wr(A_CTRL, 32'd1);
        wr(A_CNT, 32'd100);
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'd100) begin n_bad++; $display("FAIL col_count got %0d exp 100", d); end
        wr(A_CTRL, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CNT, 32'd50);
        wr(A_CTRL, 32'd3);
        wr(A_STAT, 32'd1);
        rd(A_STAT, s, h);
        rd(A_CNT, d, h);
        n_cmp++; if (s !== 32'd1 || d !== 32'd0) begin n_bad++; $display("FAIL col_w1c got %h/%0d exp 1/0", s, d); end
        wr(A_CTRL, 32'd0);
        wr(A_STAT, 32'd0);
        rd(A_STAT, s, h);
        n_cmp++; if (s !== 32'd1) begin n_bad++; $display("FAIL col_w0 got %h exp 1", s); end
        wr(A_STAT, 32'd1);
        wr(A_CNT, 32'd7);
        wr(A_CMP, 32'd7);
        wr(A_CTRL, 32'd1);
        wr(A_CMP, 32'd9);
        rd(A_STAT, s, h);
        rd(A_CNT, d, h);
        n_cmp++; if (s !== 32'd1 || d !== 32'd8) begin n_bad++; $display("FAIL col_oldcmp got %h/%0d exp 1/8", s, d); end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h;
        wr(A_PRE, 32'd1);
        wr(A_CMP, 32'd2);
        wr(A_CNT, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CTRL, 32'd5);
        step(8);
        n_cmp++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL rst_pre_irq got %b exp 1", IRQ); end
        Addr = A_CNT; drv_data = 32'd55; drv_en = 1; R_W = 1; CS = 1;
        #2;
        RST = 0;
        #1;
        n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b exp 0", IRQ); end
        CS = 0; R_W = 0; drv_en = 0;
        #1;
        RST = 1;
        rd(A_CTRL, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl got %h exp 0", d); end
        rd(A_CNT, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_count got %h exp 0", d); end
        rd(A_CMP, d, h);
        n_cmp++; if (d !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL rst_compare got %h exp ffffffff", d); end
        rd(A_STAT, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_status got %h exp 0", d); end
        rd(A_PRE, d, h);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_presc got %h exp 0", d); end
        rd(12'h008, d, h);
        n_cmp++; if (h !== 1'b0 || !(d === 'z || d === '0)) begin n_bad++; $display("FAIL rst_data_z got %h/%b exp z/0", d, h); end
    endtask

    initial begin
        RST = 0; CS = 0; R_W = 0; Addr = '0;
        drv_data = '0; drv_en = 0;
        #12;
        RST = 1;
        step(1);
        test_por();
        test_decode();
        test_prescale();
        test_match();
        test_wrap();
        test_collision();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
